// File: rtl/norm_arb_pkg.sv
// Shared definitions for the normalizing arbiter: FSM state encoding and
// default operand / shift-count widths.
package norm_arb_pkg;

  localparam int X_LEN_DEF   = 74;
  localparam int SHIFT_W_DEF = 7;

  // IDLE: accepting, DETECT: leading-zero count, SHIFT: normalize, DONE: presenting
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DETECT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/norm_arb_lzd.sv
// Leading-zero detector for the normalizer. Counts zeros in bits
// [X_LEN-2:0] scanning from bit X_LEN-2 downwards. The top bit is the
// overflow position: when set, the count is forced to 0 (no shift). An
// all-zero operand reports the all-ones count.
module LZD_top
  import norm_arb_pkg::*;
#(
  parameter int X_LEN   = X_LEN_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic [X_LEN-1:0]   operand,
  output logic [SHIFT_W-1:0] count,
  output logic               zero,
  output logic               ovf
);

  logic [SHIFT_W-1:0] lead_cnt;
  logic               found;

  // Priority scan from bit X_LEN-2 down to bit 0 for the first one
  always_comb begin
    lead_cnt = '1;
    found    = 1'b0;
    for (int i = X_LEN - 2; i >= 0; i--) begin
      if (!found && operand[i]) begin
        lead_cnt = SHIFT_W'(X_LEN - 2 - i);
        found    = 1'b1;
      end
    end
  end

  assign zero  = ~|operand;
  assign ovf   = operand[X_LEN-1];
  assign count = ovf ? '0 : (zero ? '1 : lead_cnt);

endmodule

// File: rtl/norm_arb.sv
// Two-requester normalizing arbiter. Requester 0 (FMA) and requester 1
// (FADD) present unnormalized mantissas; one is granted, its leading-zero
// count is found and the mantissa is shifted so the leading one sits at
// bit X_LEN-2. One operation is in flight at a time (IDLE->DETECT->SHIFT->DONE).
//
// Build option: define NORM_ARB_RR_EN for round-robin arbitration on
// conflict; otherwise requester 0 always wins a conflict.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready_o is only ever raised in IDLE, one-hot on the granted
// requester; out_valid_o stays up with all outputs frozen until out_ready_i.
module norm_arb
  import norm_arb_pkg::*;
#(
  parameter int X_LEN   = X_LEN_DEF,
  parameter int SHIFT_W = $clog2(X_LEN),
  parameter int TAG_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [X_LEN-1:0]   req0_data_i,
  input  logic [X_LEN-1:0]   req1_data_i,
  input  logic [TAG_W-1:0]   req0_tag_i,
  input  logic [TAG_W-1:0]   req1_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [X_LEN-1:0]   out_data_o,
  output logic [SHIFT_W-1:0] out_shift_o,
  output logic               out_zero_o,
  output logic               out_ovf_o,
  output logic               out_src_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  state_t             state;
  logic [X_LEN-1:0]   operand_q;
  logic [1:0]         grant;
  logic [SHIFT_W-1:0] lzd_count;
  logic               lzd_zero;
  logic               lzd_ovf;

`ifdef NORM_ARB_RR_EN
  // Points at the requester that wins the next conflict
  logic ptr;

  // Round-robin grant: on conflict the pointer's requester wins
  always_comb begin
    grant = req_valid_i;
    if (req_valid_i == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the requester that lost after every accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= 1'b0;
    end else if (state == IDLE && |grant) begin
      ptr <= grant[0];
    end
  end
`else
  // Fixed priority grant: requester 0 always wins a conflict
  always_comb begin
    grant = {req_valid_i[1] & ~req_valid_i[0], req_valid_i[0]};
  end
`endif

  // Ready only while idle and out of reset, one-hot on the grant
  assign req_ready_o = (state == IDLE && rst_ni) ? grant : 2'b00;

  LZD_top #(
    .X_LEN   (X_LEN),
    .SHIFT_W (SHIFT_W)
  ) u_lzd (
    .operand (operand_q),
    .count   (lzd_count),
    .zero    (lzd_zero),
    .ovf     (lzd_ovf)
  );

  // Operation sequencer: capture, count, shift, then hold until consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      operand_q   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_shift_o <= '0;
      out_zero_o  <= 1'b0;
      out_ovf_o   <= 1'b0;
      out_src_o   <= 1'b0;
      out_tag_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            operand_q <= grant[1] ? req1_data_i : req0_data_i;
            out_tag_o <= grant[1] ? req1_tag_i : req0_tag_i;
            out_src_o <= grant[1];
            state     <= DETECT;
          end
        end
        DETECT: begin
          out_shift_o <= lzd_count;
          out_zero_o  <= lzd_zero;
          out_ovf_o   <= lzd_ovf;
          state       <= SHIFT;
        end
        SHIFT: begin
          // Overflow carries a zero count, so it passes through unshifted
          out_data_o  <= out_zero_o ? '0 : (operand_q << out_shift_o);
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_arb.sv
// Directed bench for norm_arb with a scoreboard queue. Expected results are
// pushed when a request is granted; a monitor pops and compares whenever a
// result is consumed. Aware of the NORM_ARB_RR_EN build option.
module tb_norm_arb;
  import norm_arb_pkg::*;

  localparam int XL = 74;
  localparam int SW = 7;
  localparam int TW = 5;
  localparam int RW = XL + SW + 3 + TW;

  logic          clk;
  logic          rst_ni;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready_o;
  logic [XL-1:0] req0_data;
  logic [XL-1:0] req1_data;
  logic [TW-1:0] req0_tag;
  logic [TW-1:0] req1_tag;
  logic          out_valid_o;
  logic          out_ready;
  logic [XL-1:0] out_data_o;
  logic [SW-1:0] out_shift_o;
  logic          out_zero_o;
  logic          out_ovf_o;
  logic          out_src_o;
  logic [TW-1:0] out_tag_o;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e;
  int            n_vec;
  int            n_err;
  int            n_out;

  norm_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req0_data_i (req0_data),
    .req1_data_i (req1_data),
    .req0_tag_i  (req0_tag),
    .req1_tag_i  (req1_tag),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .out_data_o  (out_data_o),
    .out_shift_o (out_shift_o),
    .out_zero_o  (out_zero_o),
    .out_ovf_o   (out_ovf_o),
    .out_src_o   (out_src_o),
    .out_tag_o   (out_tag_o)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [XL-1:0] d, input logic [SW-1:0] s,
                                         input logic z, input logic o, input logic src,
                                         input logic [TW-1:0] t);
    return {d, s, z, o, src, t};
  endfunction

  // Monitor: compare every consumed result against the head of the queue
  always @(negedge clk) begin
    if (rst_ni && out_valid_o && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got data %0h required none", out_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data",  128'(out_data_o),  128'(mon_e[RW-1 -: XL]));
        check("out_shift", 128'(out_shift_o), 128'(mon_e[RW-XL-1 -: SW]));
        check("out_zero",  128'(out_zero_o),  128'(mon_e[TW+2]));
        check("out_ovf",   128'(out_ovf_o),   128'(mon_e[TW+1]));
        check("out_src",   128'(out_src_o),   128'(mon_e[TW]));
        check("out_tag",   128'(out_tag_o),   128'(mon_e[TW-1:0]));
        n_out++;
      end
    end
  end

  // Driver: raise one requester's valid, wait for its accept, push expectation
  task automatic issue(input int r, input logic [XL-1:0] data, input logic [TW-1:0] tag,
                       input logic [XL-1:0] e_data, input logic [SW-1:0] e_shift,
                       input logic e_zero, input logic e_ovf);
    bit got = 1'b0;
    @(posedge clk); #2;
    if (r == 0) begin
      req0_data = data;
      req0_tag  = tag;
    end else begin
      req1_data = data;
      req1_tag  = tag;
    end
    req_valid[r] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready_o[r]) begin
        got = 1'b1;
        break;
      end
    end
    check("accept", 128'(got), 128'(1));
    if (got) exp_q.push_back(pack(e_data, e_shift, e_zero, e_ovf, r[0], tag));
    @(posedge clk); #2;
    req_valid[r] = 1'b0;
  endtask

  // Wait until every expected result has been delivered
  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 128'(done), 128'(1));
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_valid", 128'(seen), 128'(1));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_ni = 1'b0;
    @(posedge clk); #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [1:0] expg;
    int         base;
    n_vec = 0;
    n_err = 0;
    n_out = 0;
    rst_ni    = 1'b0;
    req_valid = 2'b11;
    out_ready = 1'b1;
    req0_data = '0;
    req1_data = '0;
    req0_tag  = '0;
    req1_tag  = '0;

    // Reset state, with both requesters pushing
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(req_ready_o), 128'(0));
    check("rst_valid", 128'(out_valid_o), 128'(0));
    check("rst_data",  128'(out_data_o),  128'(0));
    check("rst_shift", 128'(out_shift_o), 128'(0));
    check("rst_flags", 128'({out_zero_o, out_ovf_o, out_src_o}), 128'(0));
    check("rst_tag",   128'(out_tag_o),   128'(0));
    @(posedge clk); #2;
    req_valid = 2'b00;
    rst_ni    = 1'b1;

    // Lowest bit only: shift 72, leading one at bit 72, valid at N+2
    issue(0, 74'h1, 5'd3, {2'b01, 72'h0}, 7'd72, 1'b0, 1'b0);
    @(negedge clk); check("lat_n1", 128'(out_valid_o), 128'(0));
    @(negedge clk); check("lat_n2", 128'(out_valid_o), 128'(0));
    @(negedge clk); check("lat_n3", 128'(out_valid_o), 128'(1));
    drain();

    // Overflow bit set on requester 1: unshifted pass-through
    issue(1, {1'b1, 73'h1234}, 5'd17, {1'b1, 73'h1234}, 7'd0, 1'b0, 1'b1);
    drain();

    // All-zero operand
    issue(0, 74'h0, 5'd9, 74'h0, 7'd127, 1'b1, 1'b0);
    drain();

    // Already normalized (bit 72 set, no overflow)
    issue(1, {2'b01, 72'hABC}, 5'd4, {2'b01, 72'hABC}, 7'd0, 1'b0, 1'b0);
    drain();

    // Leading one at bit 40 with low bits trailing
    issue(0, {33'd0, 1'b1, 40'd5}, 5'd22, {1'b0, 1'b1, 40'd5, 32'd0}, 7'd32, 1'b0, 1'b0);
    drain();

    // Backpressure: five stalled cycles in DONE, both requesters pushing
    @(posedge clk); #2;
    out_ready = 1'b0;
    issue(0, 74'hF0, 5'd30, {1'b0, 4'hF, 69'd0}, 7'd65, 1'b0, 1'b0);
    wait_valid();
    @(posedge clk); #2;
    req0_data = 74'h7;
    req1_data = 74'h9;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 128'(out_valid_o), 128'(1));
      check("stall_data",  128'(out_data_o),  128'({1'b0, 4'hF, 69'd0}));
      check("stall_shift", 128'(out_shift_o), 128'(65));
      check("stall_tag",   128'(out_tag_o),   128'(30));
      check("stall_ready", 128'(req_ready_o), 128'(0));
    end
    @(posedge clk); #2;
    req_valid = 2'b00;
    base      = n_out;
    out_ready = 1'b1;
    drain();
    check("stall_delivered", 128'(n_out - base), 128'(1));

    // Reset while in SHIFT abandons the operation
    issue(0, 74'h55, 5'd7, 74'h0, 7'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_state", 128'(dut.state), 128'(IDLE));
    check("rst_mid_valid", 128'(out_valid_o), 128'(0));
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_data", 128'(out_data_o), 128'(0));
    @(posedge clk); #2;
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_valid", 128'(out_valid_o), 128'(0));
    end
    issue(1, 74'h2, 5'd12, {2'b01, 72'h0}, 7'd71, 1'b0, 1'b0);
    drain();

    // Both requesters held valid: grant sequence from a fresh pointer
    pulse_reset();
    @(posedge clk); #2;
    req0_data = 74'h100;
    req0_tag  = 5'd10;
    req1_data = 74'h3;
    req1_tag  = 5'd11;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      bit got = 1'b0;
`ifdef NORM_ARB_RR_EN
      expg = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
      expg = 2'b01;
`endif
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (|req_ready_o) begin
          got = 1'b1;
          break;
        end
      end
      check("grant", 128'(req_ready_o), 128'(expg));
      if (got) begin
        if (expg[0]) exp_q.push_back(pack({2'b01, 72'h0}, 7'd64, 1'b0, 1'b0, 1'b0, 5'd10));
        else         exp_q.push_back(pack({3'b011, 71'h0}, 7'd71, 1'b0, 1'b0, 1'b1, 5'd11));
      end
      @(posedge clk);
    end
    #2;
    req_valid = 2'b00;
    drain();

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
